// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int DEF_LOCK_MAX = 16;
  localparam int NUM_PORTS    = 2;
  localparam int NUM_LANES    = 4;

  function automatic arb_state_e own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

  // Counter wide enough to hold LOCK_MAX-1 with headroom for the increment.
  function automatic int lock_cnt_width(input int lock_max);
    return (lock_max > 1) ? $clog2(lock_max) + 1 : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9
);
  import dmem_arb_pkg::*;

  logic                     req0;
  logic                     lock0;
  logic                     we0;
  logic [NUM_LANES-1:0]     be0;
  logic [ADDRESS_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0]    wdata0;
  logic                     gnt0;
  logic                     rvalid0;
  logic [DATA_WIDTH-1:0]    rdata0;

  logic                     req1;
  logic                     lock1;
  logic                     we1;
  logic [NUM_LANES-1:0]     be1;
  logic [ADDRESS_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0]    wdata1;
  logic                     gnt1;
  logic                     rvalid1;
  logic [DATA_WIDTH-1:0]    rdata1;

  logic [ADDRESS_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0]    WD;
  logic                     WE0;
  logic                     WE1;
  logic                     WE2;
  logic                     WE3;
  logic [DATA_WIDTH-1:0]    RD;

  // Arbiter view.
  modport slave (
    input  req0, lock0, we0, be0, addr0, wdata0,
    input  req1, lock1, we1, be1, addr1, wdata1,
    input  RD,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output A, WD, WE0, WE1, WE2, WE3
  );

  // Requester/memory view.
  modport master (
    output req0, lock0, we0, be0, addr0, wdata0,
    output req1, lock1, we1, be1, addr1, wdata1,
    output RD,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  A, WD, WE0, WE1, WE2, WE3
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on contention the port that did not win last time wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with round-robin contention, bounded port locking
// and a one-cycle registered read return per port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9,
  parameter int LOCK_MAX      = DEF_LOCK_MAX
) (
  input logic           CLK,
  input logic           RST,
  dmem_arbiter_if.slave bus
);

  localparam int               CNT_W     = lock_cnt_width(LOCK_MAX);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_e               state_reg;
  arb_state_e               state_next;
  logic                     last_grant_reg;
  logic                     last_grant_next;
  logic [CNT_W-1:0]         lock_cnt_reg;
  logic [CNT_W-1:0]         lock_cnt_next;
  logic [CNT_W-1:0]         lock_cnt_inc;

  logic [NUM_PORTS-1:0]     req_vec;
  logic [NUM_PORTS-1:0]     lock_vec;
  logic [NUM_PORTS-1:0]     we_vec;
  logic [NUM_LANES-1:0]     be_vec    [NUM_PORTS];
  logic [ADDRESS_WIDTH-1:0] addr_vec  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]    wdata_vec [NUM_PORTS];

  logic [NUM_PORTS-1:0]     rr_grant;
  logic [NUM_PORTS-1:0]     gnt_vec;
  logic                     gnt_any;
  logic                     gnt_port;
  logic                     own_port;

  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic                     sel_we;
  logic [NUM_LANES-1:0]     sel_be;
  logic [NUM_LANES-1:0]     we_lane;

  logic [NUM_PORTS-1:0]     rvalid_vec;
  logic [DATA_WIDTH-1:0]    rdata_vec [NUM_PORTS];

  genvar gi;

  assign req_vec      = {bus.req1, bus.req0};
  assign lock_vec     = {bus.lock1, bus.lock0};
  assign we_vec       = {bus.we1, bus.we0};
  assign be_vec[0]    = bus.be0;
  assign be_vec[1]    = bus.be1;
  assign addr_vec[0]  = bus.addr0;
  assign addr_vec[1]  = bus.addr1;
  assign wdata_vec[0] = bus.wdata0;
  assign wdata_vec[1] = bus.wdata1;

  rr_pick2 u_pick (
    .req   (req_vec),
    .last  (last_grant_reg),
    .grant (rr_grant)
  );

  // Grant is combinational in the request cycle; an owner excludes the other port.
  always_comb begin
    gnt_vec = '0;
    if (!RST) begin
      case (state_reg)
        IDLE:    gnt_vec    = rr_grant;
        OWN0:    gnt_vec[0] = req_vec[0];
        OWN1:    gnt_vec[1] = req_vec[1];
        default: gnt_vec    = '0;
      endcase
    end
  end

  assign gnt_any      = |gnt_vec;
  assign gnt_port     = gnt_vec[1];
  assign own_port     = (state_reg == OWN1);
  assign lock_cnt_inc = lock_cnt_reg + CNT_W'(1);

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    lock_cnt_next   = lock_cnt_reg;
    if (gnt_any) begin
      last_grant_next = gnt_port;
    end
    case (state_reg)
      IDLE: begin
        lock_cnt_next = '0;
        if (gnt_any && lock_vec[gnt_port] && (lock_cnt_reg < LOCK_LAST)) begin
          state_next = own_state(gnt_port);
        end
      end
      OWN0, OWN1: begin
        // Hitting the lock limit releases the bus; last_grant already names the
        // owner, so the other port wins the next contention.
        if (!req_vec[own_port] || !lock_vec[own_port] || (lock_cnt_inc >= LOCK_LAST)) begin
          state_next    = IDLE;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt_inc;
        end
      end
      default: begin
        state_next    = IDLE;
        lock_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      lock_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      lock_cnt_reg   <= lock_cnt_next;
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    if (gnt_any) begin
      sel_addr  = addr_vec[gnt_port];
      sel_wdata = wdata_vec[gnt_port];
      sel_we    = we_vec[gnt_port];
      sel_be    = be_vec[gnt_port];
    end
  end

  for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign we_lane[gi] = gnt_any & sel_we & sel_be[gi];
  end

  // Per-port read return; reset also masks an rvalid already in flight.
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge CLK) begin
      if (RST) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= gnt_vec[gi] & ~we_vec[gi];
        if (gnt_vec[gi] && !we_vec[gi]) begin
          rdata_reg <= bus.RD;
        end
      end
    end

    assign rvalid_vec[gi] = rvalid_reg & ~RST;
    assign rdata_vec[gi]  = rdata_reg;
  end

  assign bus.gnt0    = gnt_vec[0];
  assign bus.gnt1    = gnt_vec[1];
  assign bus.rvalid0 = rvalid_vec[0];
  assign bus.rvalid1 = rvalid_vec[1];
  assign bus.rdata0  = rdata_vec[0];
  assign bus.rdata1  = rdata_vec[1];

  assign bus.A   = sel_addr;
  assign bus.WD  = sel_wdata;
  assign bus.WE0 = we_lane[0];
  assign bus.WE1 = we_lane[1];
  assign bus.WE2 = we_lane[2];
  assign bus.WE3 = we_lane[3];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random bench for dmem_arbiter with a byte-lane memory model
// and a per-port read scoreboard.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic mem_init = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem    [128];
  logic [31:0] sbq    [2][$];
  logic        exp_rv [2];
  logic [31:0] hold   [2];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  dmem_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .LOCK_MAX      (16)
  ) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Combinational-read memory with byte-lane writes.
  assign bus.RD = mem[bus.A[8:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else begin
      if (bus.WE0) mem[bus.A[8:2]][7:0]   <= bus.WD[7:0];
      if (bus.WE1) mem[bus.A[8:2]][15:8]  <= bus.WD[15:8];
      if (bus.WE2) mem[bus.A[8:2]][23:16] <= bus.WD[23:16];
      if (bus.WE3) mem[bus.A[8:2]][31:24] <= bus.WD[31:24];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic note(input string s);
    $display("[%0t] %s", $time, s);
  endtask

  task automatic drive(input int p, input logic req, input logic lock, input logic we,
                       input logic [3:0] be, input logic [8:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.req0 = req; bus.lock0 = lock; bus.we0 = we;
      bus.be0 = be; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = req; bus.lock1 = lock; bus.we1 = we;
      bus.be1 = be; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  task automatic idle_port(input int p);
    drive(p, 1'b0, 1'b0, 1'b0, 4'h0, 9'h000, 32'h0);
  endtask

  task automatic idle_all();
    idle_port(0);
    idle_port(1);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for one port: expected read data is pushed at grant, popped on rvalid.
  task automatic sb_port(input int p, input logic gnt, input logic we, input logic [8:0] addr,
                         input logic rvalid, input logic [31:0] rdata);
    check($sformatf("rvalid%0d_timing", p), 64'(rvalid), 64'(exp_rv[p]));
    if (exp_rv[p] && sbq[p].size() > 0) begin
      hold[p] = sbq[p].pop_front();
      if (rvalid) check($sformatf("rdata%0d", p), 64'(rdata), 64'(hold[p]));
    end else if (!rvalid) begin
      check($sformatf("rdata%0d_hold", p), 64'(rdata), 64'(hold[p]));
    end
    exp_rv[p] = gnt && !we;
    if (gnt && !we) sbq[p].push_back(mem[addr[8:2]]);
  endtask

  task automatic sample();
    @(negedge clk);
    check("gnt_exclusive", 64'(bus.gnt0 & bus.gnt1), 64'd0);
    if (rst) begin
      check("rst_gnt0", 64'(bus.gnt0), 64'd0);
      check("rst_gnt1", 64'(bus.gnt1), 64'd0);
      check("rst_rvalid0", 64'(bus.rvalid0), 64'd0);
      check("rst_rvalid1", 64'(bus.rvalid1), 64'd0);
      for (int p = 0; p < 2; p++) begin
        sbq[p].delete();
        exp_rv[p] = 1'b0;
        hold[p]   = 32'h0;
      end
    end else begin
      sb_port(0, bus.gnt0, bus.we0, bus.addr0, bus.rvalid0, bus.rdata0);
      sb_port(1, bus.gnt1, bus.we1, bus.addr1, bus.rvalid1, bus.rdata1);
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = 1'b0;
      hold[p]   = 32'h0;
    end
    idle_all();
    rst = 1'b1;
    mem_init = 1'b1;

    note("reset with both ports requesting");
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h010, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 9'h020, 32'h0);
    repeat (2) begin
      sample();
      advance();
    end
    rst = 1'b0;
    mem_init = 1'b0;

    note("contention after reset: port0 then port1 reads");
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 9'h020, 32'h0);
    sample();
    check("c0_gnt0", 64'(bus.gnt0), 64'd1);
    check("c0_gnt1", 64'(bus.gnt1), 64'd0);
    check("c0_A", 64'(bus.A), 64'h010);
    advance();
    sample();
    check("c1_gnt0", 64'(bus.gnt0), 64'd0);
    check("c1_gnt1", 64'(bus.gnt1), 64'd1);
    check("c1_A", 64'(bus.A), 64'h020);
    check("c1_rvalid0", 64'(bus.rvalid0), 64'd1);
    check("c1_rdata0", 64'(bus.rdata0), 64'hC0DE0004);
    advance();
    idle_all();
    sample();
    check("c2_rvalid1", 64'(bus.rvalid1), 64'd1);
    check("c2_rdata1", 64'(bus.rdata1), 64'hC0DE0008);
    check("c2_rvalid0", 64'(bus.rvalid0), 64'd0);
    check("idle_A", 64'(bus.A), 64'd0);
    check("idle_WD", 64'(bus.WD), 64'd0);
    check("idle_WE", 64'({bus.WE3, bus.WE2, bus.WE1, bus.WE0}), 64'd0);
    advance();

    note("port0 write be=0101 to 0x004");
    drive(0, 1'b1, 1'b0, 1'b1, 4'b0101, 9'h004, 32'hAABBCCDD);
    sample();
    check("wr_gnt0", 64'(bus.gnt0), 64'd1);
    check("wr_A", 64'(bus.A), 64'h004);
    check("wr_WD", 64'(bus.WD), 64'hAABBCCDD);
    check("wr_WE", 64'({bus.WE3, bus.WE2, bus.WE1, bus.WE0}), 64'b0101);
    advance();
    note("port0 read back 0x004");
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h004, 32'h0);
    sample();
    check("wr_no_rvalid0", 64'(bus.rvalid0), 64'd0);
    check("rd4_gnt0", 64'(bus.gnt0), 64'd1);
    advance();
    note("port1 write with be=0 to 0x008");
    idle_port(0);
    drive(1, 1'b1, 1'b0, 1'b1, 4'h0, 9'h008, 32'hFFFFFFFF);
    sample();
    check("rd4_rdata0", 64'(bus.rdata0), 64'hC0BB00DD);
    check("be0_gnt1", 64'(bus.gnt1), 64'd1);
    check("be0_WE", 64'({bus.WE3, bus.WE2, bus.WE1, bus.WE0}), 64'd0);
    advance();
    note("port1 read back 0x008");
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 9'h008, 32'h0);
    sample();
    check("be0_no_rvalid1", 64'(bus.rvalid1), 64'd0);
    advance();
    note("port0 read 0x00C");
    idle_port(1);
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h00C, 32'h0);
    sample();
    check("rd8_rdata1", 64'(bus.rdata1), 64'hC0DE0002);
    check("rdC_gnt0", 64'(bus.gnt0), 64'd1);
    advance();

    note("port1 locks for three accesses while port0 waits");
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h010, 32'h0);
      drive(1, 1'b1, (k < 3), 1'b0, 4'hF, 9'h020, 32'h0);
      sample();
      check($sformatf("lock3_gnt0_k%0d", k), 64'(bus.gnt0), 64'(k == 4));
      check($sformatf("lock3_gnt1_k%0d", k), 64'(bus.gnt1), 64'(k < 4));
      advance();
    end

    note("port1 holds lock continuously: released after LOCK_MAX grants");
    for (int k = 0; k < 17; k++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h010, 32'h0);
      drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 9'h020, 32'h0);
      sample();
      check($sformatf("lockmax_gnt1_k%0d", k), 64'(bus.gnt1), 64'(k < 16));
      check($sformatf("lockmax_gnt0_k%0d", k), 64'(bus.gnt0), 64'(k == 16));
      advance();
    end
    idle_all();
    sample();
    advance();

    note("reset while port1 owns the bus");
    drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 9'h020, 32'h0);
    sample();
    check("own1_gnt1", 64'(bus.gnt1), 64'd1);
    advance();
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h010, 32'h0);
    sample();
    advance();
    rst = 1'b0;
    sample();
    check("post_rst_gnt0", 64'(bus.gnt0), 64'd1);
    check("post_rst_gnt1", 64'(bus.gnt1), 64'd0);
    check("post_rst_rvalid1", 64'(bus.rvalid1), 64'd0);
    advance();

    note("reset the cycle after a port0 read grant");
    idle_port(1);
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h014, 32'h0);
    sample();
    check("pre_rst_gnt0", 64'(bus.gnt0), 64'd1);
    advance();
    rst = 1'b1;
    idle_all();
    sample();
    check("rst_mid_read_rvalid0", 64'(bus.rvalid0), 64'd0);
    advance();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h018, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 9'h01C, 32'h0);
    sample();
    check("after_rst_rvalid0", 64'(bus.rvalid0), 64'd0);
    check("after_rst_rdata0", 64'(bus.rdata0), 64'd0);
    check("after_rst_gnt0", 64'(bus.gnt0), 64'd1);
    advance();
    idle_all();
    sample();
    advance();

    note("random two-port traffic, 10000 cycles");
    for (int n = 0; n < 10000; n++) begin
      drive(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 9'($urandom_range(0, 511)), $urandom());
      drive(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 9'($urandom_range(0, 511)), $urandom());
      sample();
      advance();
    end
    idle_all();
    repeat (2) begin
      sample();
      advance();
    end
    check("sb0_drained", 64'(sbq[0].size()), 64'd0);
    check("sb1_drained", 64'(sbq[1].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 9, data-memory byte address width.
REQ-003 SHALL have parameter LOCK_MAX, default 16, maximum consecutive locked grants to one port.
REQ-004 SHALL have a single clock and a synchronous, active-high reset:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have, per requester port p in {0 = CPU load/store, 1 = debug/loader}:
- reqp  input  1  access request.
- lockp  input  1  keep ownership after this access.
- wep  input  1  1 = write, 0 = read.
- bep  input  4  byte enables, bit k = byte lane k.
- addrp  input  ADDRESS_WIDTH  byte address.
- wdatap  input  DATA_WIDTH  write data.
- gntp  output  1  access accepted this cycle.
- rvalidp  output  1  read data valid.
- rdatap  output  DATA_WIDTH  read data.
REQ-006 SHALL have a memory-side port:
- A  output  ADDRESS_WIDTH  memory address.
- WD  output  DATA_WIDTH  memory write data.
- WE0..WE3  output  1 each  byte-lane write strobes.
- RD  input  DATA_WIDTH  combinational memory read data.

Function
REQ-007 SHALL implement FSM states IDLE, OWN0 and OWN1; OWNp means port p holds a lock.
REQ-008 In IDLE, SHALL grant the single requester when only one of req0/req1 is high.
REQ-009 In IDLE, SHALL resolve req0 and req1 both high round-robin: grant the port not equal to last_grant.
REQ-010 SHALL update last_grant to p on every cycle gntp=1.
REQ-011 In OWNp, SHALL grant only port p; the other port's gnt stays 0 even if it requests.
REQ-012 SHALL enter OWNp from any state when gntp=1 and lockp=1 and the lock counter is below LOCK_MAX-1.
REQ-013 SHALL return to IDLE when, in OWNp, either reqp=0 or the granted access has lockp=0.
REQ-014 SHALL increment lock_cnt on every locked grant in OWNp and clear it on return to IDLE.
REQ-015 When lock_cnt reaches LOCK_MAX-1, SHALL force IDLE after the current grant with last_grant=p, so the other port wins the next contention.
REQ-016 gntp SHALL be combinational in the request cycle; at most one gnt SHALL be high per cycle.
REQ-017 During a grant, A, WD and WEk SHALL come from the granted port.
REQ-018 WEk SHALL equal gnt & we & be[k].
REQ-019 With no grant, SHALL drive A=0, WD=0 and WE0..WE3=0.
REQ-020 On a granted read, SHALL register RD into rdatap and assert rvalidp for exactly one cycle, the cycle after the grant (latency 1).
REQ-021 Writes SHALL produce no rvalid.
REQ-022 rdatap SHALL hold its last value while rvalidp=0.
REQ-023 Back-to-back granted reads from one port SHALL give rvalid on consecutive cycles.
REQ-024 be=0 writes SHALL still be granted, with no WE asserted.

Reset
REQ-025 On RST high at a CLK edge, SHALL set state=IDLE, last_grant=1 (port 0 wins first contention), lock_cnt=0, rvalid0=rvalid1=0 and rdata0=rdata1=0.
REQ-026 RST mid-lock or mid-read SHALL drop ownership and suppress the pending rvalid.
REQ-027 gnt outputs SHALL be 0 while RST is high.

Structure
REQ-028 SHALL place the state enum (IDLE/OWN0/OWN1) and the default LOCK_MAX constant in shared package dmem_arb_pkg.
REQ-029 SHALL implement the two-way round-robin pick as sub-module rr_pick2 (inputs req[1:0] and last; output onehot grant).

Verification
REQ-030 Reset, then req0=req1=1 both reads, addr0=0x010, addr1=0x020 -> gnt0=1 on cycle 0 and gnt1=1 on cycle 1; rvalid0 on cycle 1 and rvalid1 on cycle 2 with RD values of each address.
REQ-031 Port 0 write be=4'b0101, addr=0x004, wdata=0xAABBCCDD -> WE0=1, WE2=1, WE1=0, WE3=0, A=0x004, no rvalid0.
REQ-032 Port 1 lock=1 for 3 accesses then lock=0 while req0 is held high -> gnt0=0 for 4 cycles, gnt0=1 on the 5th.
REQ-033 Port 1 lock=1 held continuously with req0 high, LOCK_MAX=16 -> gnt1 for 16 consecutive cycles, then gnt0=1 on the next cycle.
REQ-034 RST asserted in the cycle after a port-0 read grant -> rvalid0=0 and state IDLE next cycle.
REQ-035 Random two-port traffic for 10k cycles -> never gnt0&gnt1, and every granted read yields exactly one rvalid.
